// File: rtl/buf_capture_reader.sv
// Capture buffer for the packed 128-bit sample stream: circular pre-trigger history,
// fixed-length record around a trigger, unpacked 96-bit AXI4-Stream replay.
module buf_capture_reader #(
  parameter int unsigned DEPTH_BITS = 9,
  parameter int unsigned PRETRIG    = 64
) (
  input  logic         aclk,
  input  logic         reset_i,
  input  logic [127:0] s_tdata,
  input  logic         s_tvalid,
  input  logic         arm_i,
  input  logic         trigger_i,
  output logic         capture_waiting,
  output logic         done_o,
  output logic         format_err_o,
  output logic [95:0]  m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast
);
  localparam int unsigned DEPTH   = 1 << DEPTH_BITS;
  localparam int unsigned POSTLEN = DEPTH - PRETRIG;

  typedef logic [DEPTH_BITS-1:0] addr_t;
  typedef logic [DEPTH_BITS:0]   cnt_t;

  localparam addr_t PRE_A   = addr_t'(PRETRIG);
  localparam cnt_t  PRE_C   = cnt_t'(PRETRIG);
  localparam cnt_t  POST_C  = cnt_t'(POSTLEN);
  localparam cnt_t  LAST_C  = cnt_t'(DEPTH - 1);
  localparam cnt_t  DEPTH_C = cnt_t'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_READOUT
  } state_t;

  state_t state_q, state_d;
  addr_t  wr_ptr_q, wr_ptr_d;
  addr_t  rd_ptr_q, rd_ptr_d;
  addr_t  trig_addr_q, trig_addr_d;
  cnt_t   cnt_q, cnt_d;
  logic   trig_pend_q, trig_pend_d;
  logic   fmt_err_q, fmt_err_d;
  logic   done_q, done_d;

  logic [127:0] mem [DEPTH];
  logic [95:0]  rdata_q;
  logic [95:0]  fifo_q [2];
  logic [1:0]   fcnt_q;
  logic         head_q;
  logic         inflight_q;
  cnt_t         issued_q;
  cnt_t         pop_cnt_q;

  logic       wr_en;
  logic       fmt_bad;
  logic       pop;
  logic       last_pop;
  logic       issue;
  logic [2:0] occ;

  assign capture_waiting = (state_q == S_ARMED);
  assign done_o          = done_q;
  assign format_err_o    = fmt_err_q;
  assign m_tvalid        = (fcnt_q != 2'd0);
  assign m_tdata         = fifo_q[head_q];
  assign m_tlast         = m_tvalid & (pop_cnt_q == LAST_C);

  assign wr_en    = s_tvalid & ((state_q == S_FILL) | (state_q == S_ARMED) | (state_q == S_POST));
  assign pop      = m_tvalid & m_tready;
  assign last_pop = pop & (pop_cnt_q == LAST_C);

  // Issue a BRAM read only if the result is guaranteed a free skid slot.
  assign occ   = 3'(fcnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == S_READOUT) & (issued_q != DEPTH_C) & (occ < 3'd2);

  always_comb begin
    fmt_bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      fmt_bad = fmt_bad | (s_tdata[16*i +: 4] != 4'h0);
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    cnt_d       = cnt_q;
    trig_pend_d = trig_pend_q;
    fmt_err_d   = fmt_err_q;
    done_d      = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + addr_t'(1);
      if (fmt_bad) fmt_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          wr_ptr_d  = '0;
          cnt_d     = '0;
          fmt_err_d = 1'b0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (s_tvalid) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_q + cnt_t'(1) == PRE_C) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (s_tvalid && (trigger_i || trig_pend_q)) begin
          trig_addr_d = wr_ptr_q;
          cnt_d       = cnt_t'(1);
          trig_pend_d = 1'b0;
          // With a one-beat post window the trigger beat completes the record.
          if (POST_C == cnt_t'(1)) begin
            rd_ptr_d = wr_ptr_q - PRE_A;
            state_d  = S_READOUT;
          end else begin
            state_d = S_POST;
          end
        end else if (trigger_i) begin
          trig_pend_d = 1'b1;
        end
      end
      S_POST: begin
        if (s_tvalid) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_q + cnt_t'(1) == POST_C) begin
            rd_ptr_d = trig_addr_q - PRE_A;
            state_d  = S_READOUT;
          end
        end
      end
      S_READOUT: begin
        if (issue) rd_ptr_d = rd_ptr_q + addr_t'(1);
        if (last_pop) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      trig_pend_q <= 1'b0;
      fmt_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      trig_pend_q <= trig_pend_d;
      fmt_err_q   <= fmt_err_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= s_tdata;
    for (int unsigned i = 0; i < 8; i++) begin
      rdata_q[12*i +: 12] <= mem[rd_ptr_q][16*i+4 +: 12];
    end
  end

  // Two-entry skid buffer fed one cycle after each issued read.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fcnt_q     <= '0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      issued_q   <= '0;
      pop_cnt_q  <= '0;
    end else if (state_q != S_READOUT) begin
      fcnt_q     <= '0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      issued_q   <= '0;
      pop_cnt_q  <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) issued_q <= issued_q + cnt_t'(1);
      if (inflight_q) fifo_q[head_q ^ fcnt_q[0]] <= rdata_q;
      if (pop) begin
        head_q    <= ~head_q;
        pop_cnt_q <= pop_cnt_q + cnt_t'(1);
      end
      fcnt_q <= fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_buf_capture_reader.sv
// Directed bench for buf_capture_reader with DEPTH=16, PRETRIG=4.
module tb_buf_capture_reader;
  logic         aclk;
  logic         reset_i;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         arm_i;
  logic         trigger_i;
  logic         capture_waiting;
  logic         done_o;
  logic         format_err_o;
  logic [95:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;

  int total = 0;
  int bad   = 0;

  buf_capture_reader #(.DEPTH_BITS(4), .PRETRIG(4)) dut (
    .aclk            (aclk),
    .reset_i         (reset_i),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .arm_i           (arm_i),
    .trigger_i       (trigger_i),
    .capture_waiting (capture_waiting),
    .done_o          (done_o),
    .format_err_o    (format_err_o),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input int n);
    logic [127:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) b[16*j+4 +: 12] = 12'((8*n + j) & 'hFFF);
    return b;
  endfunction

  function automatic logic [95:0] exp_out(input int n);
    logic [95:0] e;
    e = '0;
    for (int j = 0; j < 8; j++) e[12*j +: 12] = 12'((8*n + j) & 'hFFF);
    return e;
  endfunction

  task automatic send_beat(input int n, input logic trig, input logic arm);
    s_tdata   = beat(n);
    s_tvalid  = 1'b1;
    trigger_i = trig;
    arm_i     = arm;
    step();
    s_tvalid  = 1'b0;
    trigger_i = 1'b0;
    arm_i     = 1'b0;
  endtask

  task automatic do_arm(input logic trig);
    arm_i     = 1'b1;
    trigger_i = trig;
    step();
    arm_i     = 1'b0;
    trigger_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cw"},   128'(capture_waiting), 128'(0));
    chk({tag, "_done"}, 128'(done_o),          128'(0));
    chk({tag, "_ferr"}, 128'(format_err_o),    128'(0));
    chk({tag, "_data"}, 128'(m_tdata),         128'(0));
    chk({tag, "_vld"},  128'(m_tvalid),        128'(0));
    chk({tag, "_last"}, 128'(m_tlast),         128'(0));
  endtask

  // Called in the first READOUT cycle; consumes the record and checks done_o.
  task automatic read_record(input int base, input bit stall);
    int          k;
    int          cyc;
    int          first;
    bit          pstall;
    logic [95:0] pd;
    logic        pl;
    k = 0; cyc = 0; first = -1; pstall = 1'b0; pd = '0; pl = 1'b0;
    while (k < 16 && cyc < 200) begin
      if (!stall)      m_tready = 1'b1;
      else if (cyc < 4) m_tready = (cyc % 2 == 0);
      else             m_tready = 1'($urandom_range(0, 1));
      if (pstall) begin
        chk("hold_vld",  128'(m_tvalid), 128'(1));
        chk("hold_data", 128'(m_tdata),  128'(pd));
        chk("hold_last", 128'(m_tlast),  128'(pl));
      end
      if (m_tvalid && first < 0) begin
        first = cyc;
        if (!stall) chk("first_latency", 128'(first <= 3), 128'(1));
      end
      if (!stall && first >= 0) chk("no_gap", 128'(m_tvalid), 128'(1));
      if (m_tvalid && m_tready) begin
        chk("rd_data", 128'(m_tdata), 128'(exp_out(base + k)));
        chk("rd_last", 128'(m_tlast), 128'(k == 15));
        k++;
      end
      pstall = m_tvalid && !m_tready;
      pd     = m_tdata;
      pl     = m_tlast;
      step();
      cyc++;
    end
    chk("beat_count", 128'(k), 128'(16));
    chk("done_pulse", 128'(done_o),   128'(1));
    chk("done_vld",   128'(m_tvalid), 128'(0));
    chk("done_cw",    128'(capture_waiting), 128'(0));
    step();
    chk("done_clr",   128'(done_o),   128'(0));
  endtask

  initial begin
    reset_i   = 1'b1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    arm_i     = 1'b0;
    trigger_i = 1'b0;
    m_tready  = 1'b0;
    step();
    step();
    chk_zero("reset");
    reset_i = 1'b0;
    step();

    // 1: ramp, trigger on beat 20, arm during ARMED ignored
    do_arm(1'b0);
    chk("t1_fill_cw", 128'(capture_waiting), 128'(0));
    for (int n = 0; n < 32; n++) begin
      send_beat(n, n == 20, n == 10);
      if (n == 2)  chk("t1_cw_b2",  128'(capture_waiting), 128'(0));
      if (n == 3)  chk("t1_cw_b3",  128'(capture_waiting), 128'(1));
      if (n == 19) chk("t1_cw_b19", 128'(capture_waiting), 128'(1));
      if (n == 20) chk("t1_cw_b20", 128'(capture_waiting), 128'(0));
    end
    read_record(16, 1'b0);

    // 2: arm with trigger, trigger in FILL ignored, trigger on beat 10
    do_arm(1'b1);
    for (int n = 0; n < 22; n++) begin
      send_beat(100 + n, (n == 2) || (n == 10), 1'b0);
      if (n == 2) chk("t2_cw_b2", 128'(capture_waiting), 128'(0));
      if (n == 3) chk("t2_cw_b3", 128'(capture_waiting), 128'(1));
    end
    read_record(106, 1'b0);

    // 3: trigger without a valid beat, trigger beat 3 cycles later
    do_arm(1'b0);
    for (int n = 0; n < 10; n++) send_beat(200 + n, 1'b0, 1'b0);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    step();
    step();
    chk("t3_pend_cw", 128'(capture_waiting), 128'(1));
    send_beat(210, 1'b0, 1'b0);
    chk("t3_trig_cw", 128'(capture_waiting), 128'(0));
    for (int n = 11; n < 22; n++) send_beat(200 + n, 1'b0, 1'b0);
    read_record(206, 1'b0);

    // 4: stalls on the readout port
    do_arm(1'b0);
    for (int n = 0; n < 20; n++) send_beat(300 + n, n == 8, 1'b0);
    read_record(304, 1'b1);

    // 5: one malformed beat sets the sticky error
    do_arm(1'b0);
    for (int n = 0; n < 22; n++) begin
      if (n == 2) begin
        s_tdata  = beat(402) | 128'h5;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("t5_ferr_set", 128'(format_err_o), 128'(1));
      end else begin
        send_beat(400 + n, n == 10, 1'b0);
        if (n == 1) chk("t5_ferr_pre", 128'(format_err_o), 128'(0));
      end
    end
    read_record(406, 1'b0);
    chk("t5_ferr_after", 128'(format_err_o), 128'(1));
    do_arm(1'b0);
    chk("t5_ferr_clr", 128'(format_err_o), 128'(0));

    // 6: reset mid-POST, then mid-READOUT, then a clean capture
    for (int n = 0; n < 13; n++) send_beat(500 + n, n == 8, 1'b0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk_zero("t6_post_rst");
    for (int n = 0; n < 5; n++) send_beat(550 + n, 1'b0, 1'b0);
    chk("t6_idle_cw", 128'(capture_waiting), 128'(0));
    do_arm(1'b0);
    for (int n = 0; n < 20; n++) send_beat(600 + n, n == 8, 1'b0);
    m_tready = 1'b1;
    step();
    step();
    step();
    chk("t6_mid_vld", 128'(m_tvalid), 128'(1));
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk_zero("t6_rd_rst");
    step();
    chk("t6_rd_idle_vld", 128'(m_tvalid), 128'(0));
    do_arm(1'b0);
    for (int n = 0; n < 22; n++) send_beat(700 + n, n == 10, 1'b0);
    read_record(706, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
